// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data memory between two requesters: port 0 (CPU load/store
//   path) and port 1 (loader / debug DMA). Round-robin arbitration, a
//   req/ack handshake per port, and a CPU stall while port 0 is pending.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req/we/size/addr/wdata 0/1 requester inputs (size 01=byte, 10=half,
//                              00/11 = null access, no memory strobes)
//   ack0/1, rdata0/1           one-cycle completion pulse and load data
//   stall0                     req0 & ~ack0, freezes the CPU PC update
//   mem_addr/wdata/read/write  DataMem interface (2-bit MemRead/MemWrite)
//   mem_rdata                  DataMem read data
//   busy                       FSM not in IDLE
//   dbg_state                  current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Handshake: a requester raises reqN and holds it, together with its
// operands, until it sees ackN (a single-cycle pulse). Operands are latched
// at grant. A reqN still high in the cycle after ackN is a new request.
// rdataN is valid during ackN and holds until that port's next response.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [1:0]    size0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          stall0,
  input  logic          req1,
  input  logic          we1,
  input  logic [1:0]    size1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_read,
  output logic [1:0]    mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          last_q;
  logic          win_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  // Arbitration: a lone requester wins; on a tie the port that was not
  // served last wins.
  logic       grant_valid;
  logic       grant_sel;
  logic [1:0] sel_size;
  logic       sel_null;

  assign grant_valid = req0 | req1;
  assign grant_sel   = (req0 & req1) ? ~last_q : req1;
  assign sel_size    = grant_sel ? size1 : size0;
  assign sel_null    = (sel_size == 2'b00) | (sel_size == 2'b11);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_valid) state_d = sel_null ? S_RESP : S_ACCESS;
      S_ACCESS: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Grant latch, latency counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 4'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            win_q   <= grant_sel;
            last_q  <= grant_sel;
            we_q    <= grant_sel ? we1 : we0;
            size_q  <= sel_size;
            addr_q  <= grant_sel ? addr1 : addr0;
            wdata_q <= grant_sel ? wdata1 : wdata0;
            cnt_q   <= CNT_INIT;
            // A null access responds with zero data straight away.
            if (sel_null) begin
              if (grant_sel) rdata1_q <= '0;
              else           rdata0_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (win_q) begin
            rdata1_q <= we_q ? '0 : mem_rdata;
          end else begin
            rdata0_q <= we_q ? '0 : mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobes only while in ACCESS, ack only while in RESP
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 2'b00;
    mem_write = 2'b00;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state_q)
      S_ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = we_q ? 2'b00 : size_q;
        mem_write = we_q ? size_q : 2'b00;
      end
      S_RESP: begin
        ack0 = ~win_q;
        ack1 = win_q;
      end
      default: ;
    endcase
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign stall0    = req0 & ~ack0;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Two instances share all inputs:
//   u_lat1 (MEM_LAT=1, outputs a_*) and u_lat3 (MEM_LAT=3, outputs b_*).
//   Each test resets both and checks the instance whose latency it targets.
//   Inputs are driven on the falling edge; outputs are sampled on the
//   falling edge (or 1 time unit after an asynchronous reset assertion).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          req0, we0, req1, we1;
  logic [1:0]    size0, size1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, mem_rdata;

  // ---------------- MEM_LAT=1 outputs ----------------
  logic          a_ack0, a_ack1, a_stall0, a_busy;
  logic [DW-1:0] a_rdata0, a_rdata1, a_mem_wdata;
  logic [AW-1:0] a_mem_addr;
  logic [1:0]    a_mem_read, a_mem_write, a_dbg_state;

  // ---------------- MEM_LAT=3 outputs ----------------
  logic          b_ack0, b_ack1, b_stall0, b_busy;
  logic [DW-1:0] b_rdata0, b_rdata1, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;
  logic [1:0]    b_mem_read, b_mem_write, b_dbg_state;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .ack0(a_ack0), .rdata0(a_rdata0), .stall0(a_stall0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ack1(a_ack1), .rdata1(a_rdata1),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_rdata(mem_rdata), .busy(a_busy), .dbg_state(a_dbg_state)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .ack0(b_ack0), .rdata0(b_rdata0), .stall0(b_stall0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ack1(b_ack1), .rdata1(b_rdata1),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_rdata(mem_rdata), .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; size1 = 2'b00; addr1 = '0; wdata1 = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // ---------- reset state ----------
    @(negedge clk);
    check_val("rst_ack0",  a_ack0, 0);
    check_val("rst_ack1",  a_ack1, 0);
    check_val("rst_rd0",   a_rdata0, 0);
    check_val("rst_rd1",   a_rdata1, 0);
    check_val("rst_maddr", a_mem_addr, 0);
    check_val("rst_mwd",   a_mem_wdata, 0);
    check_val("rst_mrd",   a_mem_read, 0);
    check_val("rst_mwr",   a_mem_write, 0);
    check_val("rst_busy",  a_busy, 0);

    // ---------- T1: single halfword store, MEM_LAT=1 ----------
    do_reset();
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    @(negedge clk);  // ACCESS
    check_val("st_mwr",   a_mem_write, 2'b10);
    check_val("st_mrd",   a_mem_read, 2'b00);
    check_val("st_maddr", a_mem_addr, 16'h0010);
    check_val("st_mwd",   a_mem_wdata, 16'hBEEF);
    check_val("st_busy",  a_busy, 1);
    check_val("st_ack0a", a_ack0, 0);
    check_val("st_stall", a_stall0, 1);
    @(negedge clk);  // RESP, 3rd cycle
    check_val("st_ack0",  a_ack0, 1);
    check_val("st_ack1",  a_ack1, 0);
    check_val("st_mwr2",  a_mem_write, 2'b00);
    check_val("st_stl2",  a_stall0, 0);
    check_val("st_rd0",   a_rdata0, 0);
    req0 = 1'b0;
    @(negedge clk);
    check_val("st_ack0c", a_ack0, 0);
    check_val("st_ack1c", a_ack1, 0);
    check_val("st_idle",  a_busy, 0);

    // ---------- T2: port 1 halfword load, MEM_LAT=3 ----------
    do_reset();
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 16'h0020; mem_rdata = 16'h1234;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_val($sformatf("ld_mrd%0d", i), b_mem_read, 2'b10);
      check_val($sformatf("ld_addr%0d", i), b_mem_addr, 16'h0020);
      check_val($sformatf("ld_ack%0d", i), b_ack1, 0);
      check_val($sformatf("ld_stl%0d", i), b_stall0, 0);
    end
    @(negedge clk);  // cycle 5: RESP
    check_val("ld_ack1",  b_ack1, 1);
    check_val("ld_ack0",  b_ack0, 0);
    check_val("ld_rd1",   b_rdata1, 16'h1234);
    check_val("ld_mrd0",  b_mem_read, 2'b00);
    check_val("ld_stl",   b_stall0, 0);
    req1 = 1'b0;
    mem_rdata = 16'h9999;
    @(negedge clk);
    check_val("ld_ack1c", b_ack1, 0);
    check_val("ld_hold",  b_rdata1, 16'h1234);

    // ---------- T3: tie, both held, MEM_LAT=1 -> 0,1,0,1 ----------
    do_reset();
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b01; addr0 = 16'h0100;
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b01; addr1 = 16'h0200;
    mem_rdata = 16'h00AA;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check_val($sformatf("rr_ack0_c%0d", k), a_ack0, (k == 2 || k == 8) ? 1 : 0);
      check_val($sformatf("rr_ack1_c%0d", k), a_ack1, (k == 5 || k == 11) ? 1 : 0);
      if (k == 1 || k == 7) check_val($sformatf("rr_addr_c%0d", k), a_mem_addr, 16'h0100);
      if (k == 4 || k == 10) check_val($sformatf("rr_addr_c%0d", k), a_mem_addr, 16'h0200);
      if (k == 2) check_val("rr_rd0", a_rdata0, 16'h00AA);
      if (k == 5) check_val("rr_rd1", a_rdata1, 16'h00AA);
    end
    req0 = 1'b0; req1 = 1'b0;

    // ---------- T4: null access (size 11 store), follows T3 ----------
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b11; addr0 = 16'h0040; wdata0 = 16'h7777;
    mem_rdata = 16'hFFFF;
    @(negedge clk);  // second cycle: ack
    check_val("nl_ack0", a_ack0, 1);
    check_val("nl_rd0",  a_rdata0, 16'h0000);
    check_val("nl_mwr",  a_mem_write, 2'b00);
    check_val("nl_mrd",  a_mem_read, 2'b00);
    check_val("nl_busy", a_busy, 1);
    req0 = 1'b0;
    @(negedge clk);
    check_val("nl_ack0c", a_ack0, 0);
    check_val("nl_idle",  a_busy, 0);

    // ---------- T5: reset mid-access, then tie and operand change, MEM_LAT=3 ----------
    do_reset();
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b01; addr0 = 16'h0050; mem_rdata = 16'h5555;
    @(negedge clk);  // first ACCESS cycle
    check_val("ra_mrd1", b_mem_read, 2'b01);
    @(negedge clk);  // second ACCESS cycle
    rst_n = 1'b0;
    #1;
    check_val("ra_mrd",   b_mem_read, 2'b00);
    check_val("ra_busy",  b_busy, 0);
    check_val("ra_ack0",  b_ack0, 0);
    check_val("ra_state", b_dbg_state, 0);
    @(negedge clk);
    check_val("ra_ack0b", b_ack0, 0);
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 16'h0070;
    @(negedge clk);  // ACCESS for port 0 (tie after reset)
    check_val("oc_addr0", b_mem_addr, 16'h0010);
    check_val("oc_mrd",   b_mem_read, 2'b10);
    addr0 = 16'h0030;
    @(negedge clk);
    check_val("oc_addr1", b_mem_addr, 16'h0010);
    @(negedge clk);
    check_val("oc_addr2", b_mem_addr, 16'h0010);
    @(negedge clk);  // RESP
    check_val("oc_ack0",  b_ack0, 1);
    check_val("oc_ack1",  b_ack1, 0);
    check_val("oc_rd0",   b_rdata0, 16'h5555);
    check_val("oc_maddr", b_mem_addr, 16'h0000);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // ---------- report ----------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
